block_data_memory: RTL and testbench

//  Block-organised data memory directly downstream of the data cache. Services whole-block
//  (32-bit) refill reads and write-backs from the cache controller over a mem_read/mem_write/
//  mem_busywait handshake with a fixed, parameterised access latency. Also keeps saturating

---
 rtl/block_data_memory.sv | 116 +++++++++++
 tb/tb_block_data_memory.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/block_data_memory.sv
// block_data_memory: block-organised backing store behind the data cache with a fixed-latency
// busywait handshake and saturating read/write access counters.
module block_data_memory #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_writedata,
    output logic [DATA_WIDTH-1:0] mem_readdata,
    output logic                  mem_busywait,
    output logic [CNT_WIDTH-1:0]  read_count,
    output logic [CNT_WIDTH-1:0]  write_count
);
    localparam int         DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [7:0] LOAD  = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state;
    state_t                next_state;
    logic [7:0]            counter;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  request;
    logic                  accept;
    logic                  commit;
    logic                  commit_write;
    logic [ADDR_WIDTH-1:0] commit_addr;
    logic [DATA_WIDTH-1:0] commit_data;

    assign request = mem_read | mem_write;
    assign accept  = (state == IDLE) && request;

    // Commit selection: a single-cycle latency commits at the acceptance edge straight from the inputs;
    // a write wins when both request lines are high
    always_comb begin
        commit       = ((state == BUSY) && (counter == 8'd0)) || (accept && (LATENCY == 1));
        commit_write = (state == IDLE) ? mem_write : write_q;
        commit_addr  = (state == IDLE) ? mem_address : addr_q;
        commit_data  = (state == IDLE) ? mem_writedata : data_q;
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic: DONE always returns to IDLE so a waiting request is re-evaluated there
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = request ? ((LATENCY == 1) ? DONE : BUSY) : IDLE;
            BUSY:    next_state = (counter == 8'd0) ? DONE : BUSY;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: busywait tracks the request combinationally in IDLE so it rises immediately
    always_comb begin
        mem_busywait = (state == IDLE) ? request : (state == BUSY);
    end

    // Request latch and latency countdown; later changes on the inputs are ignored
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            counter <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
        end else if (accept) begin
            counter <= LOAD;
            addr_q  <= mem_address;
            data_q  <= mem_writedata;
            write_q <= mem_write;
        end else if ((state == BUSY) && (counter != 8'd0)) begin
            counter <= counter - 8'd1;
        end
    end

    // Read data register: only updated by a committed read, otherwise holds
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                      mem_readdata <= '0;
        else if (commit && !commit_write) mem_readdata <= mem[commit_addr];
    end

    // Saturating access counters, bumped once per committed access
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_count  <= '0;
            write_count <= '0;
        end else if (commit) begin
            if (commit_write && (write_count != '1))  write_count <= write_count + 1'b1;
            if (!commit_write && (read_count != '1))  read_count  <= read_count + 1'b1;
        end
    end

    // Block storage, cleared on reset so an aborted write leaves no trace
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit && commit_write) begin
            mem[commit_addr] <= commit_data;
        end
    end
endmodule

// File: tb/tb_block_data_memory.sv
// tb_block_data_memory: scoreboard bench for block_data_memory with a reference memory model
module tb_block_data_memory;
    localparam int AW  = 6;
    localparam int DW  = 32;
    localparam int LAT = 5;
    localparam int CW  = 3;
    localparam int MAXC = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [AW-1:0] mem_address = '0;
    logic [DW-1:0] mem_writedata = '0;
    logic [DW-1:0] mem_readdata;
    logic          mem_busywait;
    logic [CW-1:0] read_count;
    logic [CW-1:0] write_count;

    block_data_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_busywait(mem_busywait), .read_count(read_count), .write_count(write_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] rdata;
        logic [CW-1:0] rc;
        logic [CW-1:0] wc;
    } exp_t;

    exp_t          sbq[$];
    exp_t          e;
    logic [DW-1:0] ref_mem [2**AW];
    logic [DW-1:0] ref_last;
    int            ref_rc;
    int            ref_wc;
    int            tests = 0;
    int            fails = 0;
    int            run = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
        ref_last = '0;
        ref_rc = 0;
        ref_wc = 0;
    endtask

    // Monitor: a response is the cycle where the request is still held but busywait has dropped
    always @(negedge clock) begin
        if (!reset) run = 0;
        else if (mem_busywait) run++;
        else if (mem_read | mem_write) begin
            check("busy_cycles", 64'(run), 64'(LAT + 1));
            run = 0;
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_response: got response expected none at %0t", $time);
            end else begin
                e = sbq.pop_front();
                check("readdata", 64'(mem_readdata), 64'(e.rdata));
                check("read_count", 64'(read_count), 64'(e.rc));
                check("write_count", 64'(write_count), 64'(e.wc));
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input bit mutate);
        int n;
        bit done;
        @(posedge clock);
        #1;
        mem_read = rd;
        mem_write = wr;
        mem_address = addr;
        mem_writedata = data;
        if (wr) begin
            ref_mem[addr] = data;
            if (ref_wc < MAXC) ref_wc++;
        end else begin
            ref_last = ref_mem[addr];
            if (ref_rc < MAXC) ref_rc++;
        end
        sbq.push_back('{rdata: ref_last, rc: CW'(ref_rc), wc: CW'(ref_wc)});
        n = 0;
        done = 0;
        while (!done && n < 40) begin
            @(negedge clock);
            n++;
            if (!mem_busywait) done = 1;
            else if (mutate && n >= 2) begin
                mem_address = AW'($urandom);
                mem_writedata = $urandom;
            end
        end
        check("handshake_done", 64'(done), 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            mem_read = 1'b0;
            mem_write = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        check("rst_busywait", 64'(mem_busywait), 64'd0);
        check("rst_readdata", 64'(mem_readdata), 64'd0);
        reset = 1'b1;

        // single write then read of the same block
        issue(1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, 1'b0);
        idle(1);
        issue(1'b1, 1'b0, 6'h2A, 32'h0, 1'b0);
        idle(1);
        check("cnt_w1", 64'(write_count), 64'd1);
        check("cnt_r1", 64'(read_count), 64'd1);

        // write-back immediately followed by refill, then confirm the written block
        issue(1'b0, 1'b1, 6'h05, 32'h11223344, 1'b0);
        issue(1'b1, 1'b0, 6'h3F, 32'h0, 1'b0);
        idle(2);
        issue(1'b1, 1'b0, 6'h05, 32'h0, 1'b0);

        // inputs scrambled while busy must not affect the latched write
        issue(1'b0, 1'b1, 6'h07, 32'hCAFEF00D, 1'b1);
        idle(1);
        issue(1'b1, 1'b0, 6'h07, 32'h0, 1'b0);
        idle(1);

        // reset in the middle of a write aborts it and clears everything
        @(posedge clock);
        #1;
        mem_write = 1'b1;
        mem_address = 6'h10;
        mem_writedata = 32'h55AA55AA;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        mem_write = 1'b0;
        sbq.delete();
        model_reset();
        #1;
        check("mid_rst_busywait", 64'(mem_busywait), 64'd0);
        check("mid_rst_readdata", 64'(mem_readdata), 64'd0);
        check("mid_rst_rc", 64'(read_count), 64'd0);
        check("mid_rst_wc", 64'(write_count), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        issue(1'b1, 1'b0, 6'h10, 32'h0, 1'b0);
        idle(1);
        issue(1'b1, 1'b0, 6'h2A, 32'h0, 1'b0);
        idle(1);

        // both lines high count as writes; push the write counter past saturation
        for (int i = 0; i < MAXC + 2; i++) begin
            issue(1'b1, 1'b1, AW'(i), 32'hA0000000 | 32'(i), 1'b0);
            idle(i % 2);
        end
        idle(1);
        check("wc_saturated", 64'(write_count), 64'(MAXC));
        check("rc_after_both", 64'(read_count), 64'd2);
        issue(1'b1, 1'b0, 6'h03, 32'h0, 1'b0);

        // randomized mix against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [1:0] op;
            logic [AW-1:0] a;
            op = 2'($urandom);
            a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            issue(op == 2'd0 || op == 2'd3, op != 2'd0, a, $urandom, $urandom_range(0, 3) == 0);
            idle($urandom_range(0, 2));
        end
        idle(3);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
